store_rmw_ctrl: RTL and testbench
=================================

# store_rmw_ctrl

Store-side counterpart to the load data extender. It accepts word, halfword and byte store requests from the MEM stage and writes them into a word-wide data memory that has no byte enables. Full-word stores are written directly. Partial stores run a read-modify-write sequence that merges the new bytes into the existing word.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — a store request is presented.
- `req_ready`  out  1  — the block accepts a request this cycle.
- `req_addr`  in  ADDR_W  — byte address of the store.
- `req_data`  in  32  — store data; right-aligned for SH and SB.
- `req_op`  in  3  — store op: SW=3'b000, SH=3'b100, SB=3'b010.
- `mem_addr`  out  ADDR_W  — word address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `mem_rd_en`  out  1  — memory read strobe.
- `mem_rdata`  in  32  — read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  — memory write strobe.
- `mem_wdata`  out  32  — word to write.
- `done`  out  1  — one-cycle pulse marking completion of a store.
- `err`  out  1  — one-cycle pulse marking a rejected request.

## Operation
- States: IDLE, READ, MERGE, WRITE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr, data and op.
  - SW goes to WRITE.
  - SH or SB goes to READ.
  - An illegal op pulses `err` next cycle and stays in IDLE.
- READ: `mem_rd_en`=1, `mem_addr`=latched word address → MERGE.
- MERGE:
  - `mem_wr_en`=1 and `mem_wdata`=merge(`mem_rdata`, data, op, addr[1:0]).
  - `done`=1 → IDLE.
- WRITE: `mem_wr_en`=1, `mem_wdata`=latched data, `done`=1 → IDLE.
- Merge rules:
  - SH replaces bytes [15:0] when addr[1]=0 and bytes [31:16] when addr[1]=1.
  - SB replaces byte lane addr[1:0] with data[7:0].
  - All other bytes are kept from `mem_rdata`.
- Reset values: all outputs 0 except `req_ready`=1; state=IDLE; latched registers 0.
- Reset mid-sequence aborts immediately. No `mem_wr_en` is driven after `reset_n` falls, so a partially executed RMW leaves memory unchanged.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- `req_ready`=0 in every non-IDLE state. Requests presented while busy are neither accepted nor lost; the requester holds them.

## Timing
- Request accepted at cycle N (IDLE, `req_valid` and `req_ready` both high).
- SW: write and `done` at N+1; `req_ready` high again at N+2.
- SH/SB: read at N+1, merged write and `done` at N+2; `req_ready` high at N+3.
- Back-to-back SW throughput: one store every 2 cycles. SH/SB: one every 3 cycles.
- `err` pulses at N+1 with no memory strobe asserted; `req_ready` stays high.
- `mem_wdata` in MERGE is combinational from `mem_rdata`; the memory must present read data registered before that cycle's edge.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - SW with addr[1:0]≠0, or SH with addr[0]=1, is rejected like an illegal op.
  - The block pulses `err` at N+1 and issues no memory access.
- `STORE_ALIGN_CHECK_EN` undefined:
  - SW ignores addr[1:0].
  - SH ignores addr[0].
  - Only an illegal op raises `err`.

## Structure
- Shared package holds:
  - The op encodings, common with the load extender: SW/LW 000, SH/LH 100, SB/LB 010.
  - The state enum.
  - The byte-lane constants.
- Sub-module `store_merge`: purely combinational; (old word, new data, op, addr[1:0]) → merged word. It is shared with future cache write paths.
- Top level holds the FSM, request latch and strobes.

## Test plan
- Memory word 0x11223344 at address 0x10. SW 0xDEADBEEF @0x10 → write 0xDEADBEEF at N+1, `done` at N+1, no read issued.
- Same preload. SH 0xABCD @0x12 → read at N+1, write 0xABCD3344 at N+2, `done` at N+2.
- Same preload. SB 0x5A @0x11, 0x13, 0x10 and 0x12 in turn; word restored between each → writes 0x11225A44, 0x5A223344, 0x1122335A, 0x115A3344.
- Illegal op 3'b111 → `err` at N+1, no strobes, `req_ready` stays 1. With `STORE_ALIGN_CHECK_EN` defined, SH @0x11 → `err`, memory unchanged.
- SB accepted, then `reset_n` dropped during READ → no `mem_wr_en` ever; outputs at reset values; memory unchanged.
- Back-to-back SW, SB, SW with `req_valid` held high → accepts at N, N+2, N+5; `done` at N+1, N+4, N+6.

Source files
------------

// File: rtl/store_rmw_ctrl_pkg.sv
// Shared definitions for the store path: op encodings (common with the load extender),
// sequencer states and byte-lane geometry.
package store_rmw_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    localparam int LANE_W = 8;

    // Same encodings as LW/LH/LB so decode tables stay aligned across load and store paths.
    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_SH = 3'b100;
    localparam logic [2:0] OP_SB = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic logic isStoreOp(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte-lane merge of right-aligned store data into an existing word.
// Shared with cache write paths, so it carries no state.
module store_merge
    import store_rmw_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] oldWord,
    input  logic [DATA_W-1:0] newData,
    input  logic [2:0]        op,
    input  logic [1:0]        byteOff,
    output logic [DATA_W-1:0] mergedWord
);

    always_comb begin
        // NOTE: default assignment first so every path drives mergedWord and no latch is inferred.
        mergedWord = oldWord;
        case (op)
            OP_SW:   mergedWord = newData;
            OP_SH:   mergedWord[{byteOff[1], 4'b0000} +: HALF_W] = newData[HALF_W-1:0];
            OP_SB:   mergedWord[{byteOff, 3'b000} +: LANE_W]     = newData[LANE_W-1:0];
            default: mergedWord = oldWord;
        endcase
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a word-wide memory without byte enables: SW writes directly, SH/SB do
// read-modify-write. Define STORE_ALIGN_CHECK_EN to reject misaligned SW/SH like illegal ops.
module store_rmw_ctrl
    import store_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err
);

    state_t            stateQ, stateD;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] dataQ;
    logic [2:0]        opQ;
    logic              errQ;
    logic              accept;
    logic              reqLegal;
    logic [DATA_W-1:0] mergedWord;

    assign accept = (stateQ == IDLE) && req_valid;

    always_comb begin
        reqLegal = isStoreOp(req_op);
`ifdef STORE_ALIGN_CHECK_EN
        if ((req_op == OP_SW) && (req_addr[1:0] != 2'b00)) reqLegal = 1'b0;
        if ((req_op == OP_SH) && req_addr[0])              reqLegal = 1'b0;
`endif
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (accept && reqLegal) stateD = (req_op == OP_SW) ? WRITE : READ;
            READ:    stateD = MERGE;
            MERGE:   stateD = IDLE;
            WRITE:   stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the request latch is reset too, so mem_addr/mem_wdata read back as 0 after reset.
            stateQ <= IDLE;
            addrQ  <= '0;
            dataQ  <= '0;
            opQ    <= OP_SW;
            errQ   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            stateQ <= stateD;
            errQ   <= accept && !reqLegal;
            if (accept) begin
                addrQ <= req_addr;
                dataQ <= req_data;
                opQ   <= req_op;
            end
        end
    end

    store_merge uMerge (
        .oldWord   (mem_rdata),
        .newData   (dataQ),
        .op        (opQ),
        .byteOff   (addrQ[1:0]),
        .mergedWord(mergedWord)
    );

    // Strobes decode from state alone, so an async reset drops them in the same instant.
    always_comb begin
        req_ready = (stateQ == IDLE);
        mem_rd_en = (stateQ == READ);
        mem_wr_en = (stateQ == MERGE) || (stateQ == WRITE);
        done      = mem_wr_en;
        err       = errQ;
        mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
        mem_wdata = '0;
        if (stateQ == MERGE) mem_wdata = mergedWord;
        if (stateQ == WRITE) mem_wdata = dataQ;
    end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: table of single stores against a small registered memory,
// plus reset-abort and back-to-back throughput sequences.
module tb_store_rmw_ctrl;

    localparam logic [2:0]  SW = 3'b000;
    localparam logic [2:0]  SH = 3'b100;
    localparam logic [2:0]  SB = 3'b010;
    localparam logic [31:0] PRELOAD = 32'h1122_3344;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expWord;
        bit          expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reqValid;
    logic        req_ready;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [2:0]  reqOp;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] memRdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    logic [31:0] mem [16];
    logic        plEn = 1'b0;
    logic [3:0]  plIdx = '0;
    logic [31:0] plVal = '0;
    int          rdCount = 0;
    int          wrCount = 0;

    int checks = 0;
    int errors = 0;

    store_rmw_ctrl #(.ADDR_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(reqValid),
        .req_ready(req_ready),
        .req_addr (reqAddr),
        .req_data (reqData),
        .req_op   (reqOp),
        .mem_addr (mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rdata(memRdata),
        .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Registered-read memory: data read in one cycle is visible the next.
    always @(posedge clk) begin
        if (plEn) mem[plIdx] <= plVal;
        else if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_rd_en) begin
            memRdata <= mem[mem_addr[5:2]];
            rdCount  <= rdCount + 1;
        end
        if (mem_wr_en) wrCount <= wrCount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        plEn = 1'b1; plIdx = idx; plVal = val;
        @(negedge clk);
        plEn = 1'b0;
    endtask

    task automatic runVec(input int i, input vec_t v);
        int rd0, wr0;
        bit rmw;
        rmw = (v.op != SW) && !v.expErr;
        preload(4'd4, PRELOAD);
        rd0 = rdCount; wr0 = wrCount;
        reqValid = 1'b1; reqOp = v.op; reqAddr = v.addr; reqData = v.data;
        check($sformatf("v%0d_ready_idle", i), req_ready, 1);
        @(negedge clk);
        reqValid = 1'b0;
        if (v.expErr) begin
            check($sformatf("v%0d_err", i), err, 1);
            check($sformatf("v%0d_err_strobes", i), {mem_rd_en, mem_wr_en, done}, 0);
            check($sformatf("v%0d_err_ready", i), req_ready, 1);
        end else if (!rmw) begin
            check($sformatf("v%0d_sw_strobes", i), {mem_rd_en, mem_wr_en, done}, 3'b011);
            check($sformatf("v%0d_sw_addr", i), mem_addr, 32'h10);
            check($sformatf("v%0d_sw_wdata", i), mem_wdata, v.expWord);
        end else begin
            check($sformatf("v%0d_rd_strobes", i), {mem_rd_en, mem_wr_en, done, req_ready}, 4'b1000);
            check($sformatf("v%0d_rd_addr", i), mem_addr, 32'h10);
            @(negedge clk);
            check($sformatf("v%0d_wr_strobes", i), {mem_rd_en, mem_wr_en, done}, 3'b011);
            check($sformatf("v%0d_wr_wdata", i), mem_wdata, v.expWord);
        end
        @(negedge clk);
        check($sformatf("v%0d_back_idle", i), {req_ready, done, err}, 3'b100);
        check($sformatf("v%0d_mem", i), mem[4], v.expWord);
        check($sformatf("v%0d_reads", i), rdCount - rd0, rmw ? 1 : 0);
        check($sformatf("v%0d_writes", i), wrCount - wr0, v.expErr ? 0 : 1);
    endtask

    vec_t vecs[$];
    logic [2:0]  bOp[3];
    logic [31:0] bAddr[3];
    logic [31:0] bData[3];
    int acc[3];
    int dn[3];

    initial begin
        int rd0, wr0, ai, di;
        bit acceptNow;

        vecs.push_back('{SW,    32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{SH,    32'h12, 32'h0000_ABCD, 32'hABCD_3344, 1'b0});
        vecs.push_back('{SB,    32'h11, 32'h0000_005A, 32'h1122_5A44, 1'b0});
        vecs.push_back('{SB,    32'h13, 32'h0000_005A, 32'h5A22_3344, 1'b0});
        vecs.push_back('{SB,    32'h10, 32'h0000_005A, 32'h1122_335A, 1'b0});
        vecs.push_back('{SB,    32'h12, 32'h0000_005A, 32'h115A_3344, 1'b0});
        vecs.push_back('{SH,    32'h10, 32'hFFFF_9876, 32'h1122_9876, 1'b0});
        vecs.push_back('{SB,    32'h13, 32'hAAAA_AA77, 32'h7722_3344, 1'b0});
        vecs.push_back('{3'b111, 32'h10, 32'hFFFF_FFFF, PRELOAD,      1'b1});
        vecs.push_back('{3'b001, 32'h10, 32'hFFFF_FFFF, PRELOAD,      1'b1});
`ifdef STORE_ALIGN_CHECK_EN
        vecs.push_back('{SH,    32'h11, 32'h0000_BEEF, PRELOAD,      1'b1});
        vecs.push_back('{SW,    32'h13, 32'hCAFE_F00D, PRELOAD,      1'b1});
`else
        vecs.push_back('{SH,    32'h11, 32'h0000_BEEF, 32'h1122_BEEF, 1'b0});
        vecs.push_back('{SW,    32'h13, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0});
`endif

        reset_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqData = '0; reqOp = SW;
        #1;
        check("reset_ready", req_ready, 1);
        check("reset_strobes", {mem_rd_en, mem_wr_en, done, err}, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) runVec(i, vecs[i]);

        // Reset dropped during READ of an SB must abort with no write.
        preload(4'd4, PRELOAD);
        rd0 = rdCount; wr0 = wrCount;
        reqValid = 1'b1; reqOp = SB; reqAddr = 32'h11; reqData = 32'h5A;
        @(negedge clk);
        reqValid = 1'b0;
        check("abort_in_read", mem_rd_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_ready", req_ready, 1);
        check("abort_strobes", {mem_rd_en, mem_wr_en, done, err}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_write", wrCount - wr0, 0);
        check("abort_mem", mem[4], PRELOAD);
        check("abort_idle", {req_ready, mem_wr_en}, 2'b10);

        // Back-to-back SW, SB, SW with valid held high.
        preload(4'd8, 32'h0);
        preload(4'd9, 32'h0);
        bOp   = '{SW, SB, SW};
        bAddr = '{32'h20, 32'h21, 32'h24};
        bData = '{32'h0102_0304, 32'h0000_0099, 32'hCAFE_BABE};
        acc = '{-100, -100, -100};
        dn  = '{-100, -100, -100};
        ai = 0; di = 0;
        for (int t = 0; t < 20 && di < 3; t++) begin
            if (done) begin
                if (di < 3) dn[di] = t;
                di++;
            end
            check($sformatf("b2b_no_overlap_t%0d", t), {1'b0, mem_rd_en & mem_wr_en}, 0);
            if (ai < 3) begin
                reqValid = 1'b1; reqOp = bOp[ai]; reqAddr = bAddr[ai]; reqData = bData[ai];
            end else begin
                reqValid = 1'b0;
            end
            acceptNow = (ai < 3) && req_ready;
            if (acceptNow) acc[ai] = t;
            @(negedge clk);
            if (acceptNow) ai++;
        end
        reqValid = 1'b0;
        check("b2b_all_done", di, 3);
        check("b2b_accept1", acc[1] - acc[0], 2);
        check("b2b_accept2", acc[2] - acc[0], 5);
        check("b2b_done0", dn[0] - acc[0], 1);
        check("b2b_done1", dn[1] - acc[0], 4);
        check("b2b_done2", dn[2] - acc[0], 6);
        @(negedge clk);
        check("b2b_mem8", mem[8], 32'h0102_9904);
        check("b2b_mem9", mem[9], 32'hCAFE_BABE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
